// File: rtl/psum_spad_arbiter.sv
// Arbitrates the single-port psum scratchpad between the PE accumulate path
// (atomic saturating read-modify-write), the drain path and a sequenced zero-fill clear.
module psum_spad_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  output logic                  clr_done,
  output logic                  busy,
  input  logic                  acc_req,
  input  logic                  acc_first,
  input  logic [ADDR_WIDTH-1:0] acc_addr,
  input  logic [DATA_WIDTH-1:0] acc_data,
  output logic                  acc_gnt,
  input  logic                  drn_req,
  input  logic [ADDR_WIDTH-1:0] drn_addr,
  output logic                  drn_gnt,
  output logic                  drn_valid,
  output logic [DATA_WIDTH-1:0] drn_data,
  output logic                  sat_flag,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ACC_RD, ACC_WR, DRN_RD, CLEAR} state_t;

  state_t                state;
  state_t                pick;
  logic                  decide;
  logic                  take_acc;
  logic                  take_drn;
  logic                  rr_drn;
  logic                  clr_pend;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] acc_addr_q;
  logic [DATA_WIDTH-1:0] acc_data_q;
  logic                  acc_first_q;
  logic [ADDR_WIDTH-1:0] drn_addr_q;
  logic [DATA_WIDTH:0]   sum;
  logic                  ovf;
  logic [DATA_WIDTH-1:0] sat_sum;

  // Next operation chosen at a decision point: clear, then enable, then round-robin.
  always_comb begin
    pick     = IDLE;
    take_acc = 1'b0;
    take_drn = 1'b0;
    if (clr || clr_pend) begin
      pick = CLEAR;
    end else if (en) begin
      if (acc_req && (!drn_req || !rr_drn)) begin
        take_acc = 1'b1;
        pick     = acc_first ? ACC_WR : ACC_RD;
      end else if (drn_req) begin
        take_drn = 1'b1;
        pick     = DRN_RD;
      end
    end
  end

  assign decide = (state == IDLE) || (state == ACC_WR) || (state == DRN_RD);

  // Sign-extended add one bit wider so overflow shows as a sign disagreement.
  assign sum     = {mem_rdata[DATA_WIDTH-1], mem_rdata} + {acc_data_q[DATA_WIDTH-1], acc_data_q};
  assign ovf     = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
  assign sat_sum = !ovf ? sum[DATA_WIDTH-1:0] : (sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_drn      <= 1'b0;
      clr_pend    <= 1'b0;
      clr_cnt     <= '0;
      acc_addr_q  <= '0;
      acc_data_q  <= '0;
      acc_first_q <= 1'b0;
      drn_addr_q  <= '0;
      clr_done    <= 1'b0;
      drn_valid   <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      clr_done  <= 1'b0;
      drn_valid <= (state == DRN_RD);
      case (state)
        IDLE, ACC_WR, DRN_RD: begin
          state <= pick;
          if (take_acc) begin
            acc_addr_q  <= acc_addr;
            acc_data_q  <= acc_data;
            acc_first_q <= acc_first;
          end
          if (take_drn) drn_addr_q <= drn_addr;
          // Turn passes to the other side only when both were contending.
          if (acc_req && drn_req && (take_acc || take_drn)) rr_drn <= take_acc;
          if (pick == CLEAR) begin
            clr_pend <= 1'b0;
            clr_cnt  <= '0;
          end
        end
        ACC_RD: begin
          state <= ACC_WR;
          if (clr) clr_pend <= 1'b1;
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          if (clr_cnt == LAST_ADDR) begin
            state    <= IDLE;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (state == ACC_WR && !acc_first_q && ovf) sat_flag <= 1'b1;
      else if (state == CLEAR) sat_flag <= 1'b0;
    end
  end

  // SRAM port decode; idle cycles drive all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ACC_RD: begin
        mem_en   = 1'b1;
        mem_addr = acc_addr_q;
      end
      ACC_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = acc_addr_q;
        mem_wdata = acc_first_q ? acc_data_q : sat_sum;
      end
      DRN_RD: begin
        mem_en   = 1'b1;
        mem_addr = drn_addr_q;
      end
      CLEAR: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = clr_cnt;
      end
      default: ;
    endcase
  end

  assign acc_gnt  = (state == ACC_WR);
  assign drn_gnt  = (state == DRN_RD);
  assign busy     = (state != IDLE);
  assign drn_data = drn_valid ? mem_rdata : '0;

endmodule

// File: doc/psum_spad_arbiter.md
Name: psum_spad_arbiter

Overview:
- Owns the single-port psum scratchpad and shares it between two requesters: the PE accumulate path (read-modify-write of partial sums) and the drain path (psum readout to the output buffer).
- Each accumulate is performed atomically, saturates signed sums and provides a sequenced zero-fill clear.
- Sits between the main controller/PE datapath and the psum SRAM macro.

Parameters:
- ADDR_WIDTH, 4, scratchpad address width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 16, signed psum width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  chip enable; low blocks new grants, in-flight RMW completes
- clr  in  1  one-cycle pulse; zero-fill all entries
- clr_done  out  1  one-cycle pulse after the last clear write
- busy  out  1  state != IDLE
- acc_req  in  1  accumulate request; hold with addr/data until acc_gnt
- acc_first  in  1  overwrite instead of add (first filter row)
- acc_addr  in  ADDR_WIDTH  accumulate address
- acc_data  in  DATA_WIDTH  value to add or write
- acc_gnt  out  1  pulse; write committed this cycle
- drn_req  in  1  drain request; hold with addr until drn_gnt
- drn_addr  in  ADDR_WIDTH  drain address
- drn_gnt  out  1  pulse; read issued this cycle
- drn_valid  out  1  drn_data valid (cycle after drn_gnt)
- drn_data  out  DATA_WIDTH  mem_rdata when drn_valid, else 0
- sat_flag  out  1  sticky; set on any saturated accumulate
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_WIDTH  SRAM address
- mem_wdata  out  DATA_WIDTH  SRAM write data
- mem_rdata  in  DATA_WIDTH  SRAM read data, valid one cycle after a read

Behaviour:
- Reset:
  - State IDLE, rr pointer = ACC, clear counter 0.
  - All outputs 0, including sat_flag.
  - Reset mid-RMW aborts the operation without a write.
- States:
  - IDLE, ACC_RD, ACC_WR, DRN_RD, CLEAR.
- Decision points:
  - IDLE, ACC_WR and DRN_RD each select the next state directly, so back-to-back operations have no idle bubble.
  - Priority order at a decision point:
    1. clr (latched pending if it arrives while busy) -> CLEAR.
    2. en=0 -> IDLE.
    3. Both requests present -> serve the one named by the rr pointer.
    4. One request present -> serve it.
    5. No request -> IDLE.
- Accumulate path:
  - acc with acc_first=0 -> ACC_RD: mem_en=1, we=0, addr=acc_addr.
  - acc with acc_first=1 -> straight to ACC_WR; no read is performed.
- ACC_WR:
  - mem_en=1, we=1, addr=acc_addr, acc_gnt=1.
  - wdata = acc_data if the first flag registered at grant is set, else sat(mem_rdata + acc_data).
- Saturating add:
  - Computed at DATA_WIDTH+1 bits.
  - Positive overflow -> 2^(DW-1)-1; negative overflow -> -2^(DW-1).
  - sat_flag set on either; cleared only by reset or a clr.
- DRN_RD:
  - mem_en=1, we=0, addr=drn_addr, drn_gnt=1.
  - drn_valid registered high the next cycle regardless of that cycle's state.
- RR pointer:
  - Points to the other requester after each grant.
  - Untouched when only one requester is active.
- RMW atomicity: the ACC_RD->ACC_WR pair is never split. A drain to the same address sees either the old or the fully updated value, never a partial result.
- CLEAR:
  - Writes 0 to addresses 0..2**ADDR_WIDTH-1, one per cycle.
  - clr_done pulses in the cycle after the last write; state returns to IDLE.
  - No grants issued during CLEAR.
  - clr arriving during CLEAR is ignored.
- Outputs: mem_* are combinational from state; zero when mem_en=0.
- Latency:
  - Accumulate: acc_req to acc_gnt = 2 cycles from IDLE (1 with acc_first).
  - Drain: data 1 cycle after drn_gnt.
  - Throughput 1 drain/cycle or 1 accumulate/2 cycles.

Test Plan:
- Reset, acc_first=1 addr 3 data 5, then acc addr 3 data 7 (first=0), then drain addr 3 -> acc_gnt after 1 then 2 cycles; drn_data=12 one cycle after drn_gnt.
- acc_req and drn_req held continuously from IDLE -> grant order acc, drn, acc, drn; RMW cycles never interleaved with DRN_RD.
- DW=16, mem holds 32760, acc_data 100 -> written 32767, sat_flag=1. Then -32768 + (-5) -> -32768, sat_flag stays 1.
- clr pulse, then drain all 16 addresses -> clr_done exactly 17 cycles after clr; every drn_data=0; sat_flag=0.
- en=0 during ACC_RD -> ACC_WR still completes with acc_gnt; no further grants while en=0; service resumes when en=1.
- reset asserted in ACC_RD -> no write, outputs 0 immediately; next accumulate behaves as from fresh reset.
